// File: rtl/ioblock_bank.sv
`default_nettype none
// ==========================================================================
// ioblock_bank : bank of WIDTH bidirectional I/O cells, serially configured.
//   Define IOBANK_IN_SYNC_EN for a 2-stage synchroniser on the input register.
// Rev 1.0
// ==========================================================================
module ioblock_bank #(
  parameter int WIDTH = 4
) (
  input  logic             IOCLK,
  input  logic             RESET,
  inout  wire  [WIDTH-1:0] PIN,
  input  logic [WIDTH-1:0] TS,
  input  logic [WIDTH-1:0] OUT,
  output logic [WIDTH-1:0] IN,
  input  logic             CFG_SHIFT,
  input  logic             CFG_DIN,
  input  logic             CFG_LOAD,
  output logic             CFG_DOUT
);
  localparam int CHAIN_LEN = 4 * WIDTH;

  logic [CHAIN_LEN-1:0] sr_q, sr_d;
  logic [CHAIN_LEN-1:0] act_q, act_d;
  logic [WIDTH-1:0]     qo_q, qo_d;
  logic [WIDTH-1:0]     qt_q, qt_d;
  logic [WIDTH-1:0]     d_q, d_d;
`ifdef IOBANK_IN_SYNC_EN
  logic [WIDTH-1:0]     d1_q, d1_d;
`endif

  // ACT samples the pre-shift chain, so a simultaneous shift+load commits the old contents.
  always_comb begin
    sr_d  = CFG_SHIFT ? {CFG_DIN, sr_q[CHAIN_LEN-1:1]} : sr_q;
    act_d = CFG_LOAD ? sr_q : act_q;
    qo_d  = OUT;
    qt_d  = TS;
`ifdef IOBANK_IN_SYNC_EN
    d1_d  = PIN;
    d_d   = d1_q;
`else
    d_d   = PIN;
`endif
  end

  always_ff @(posedge IOCLK or posedge RESET) begin
    if (RESET) begin
      sr_q  <= '0;
      act_q <= '0;
      qo_q  <= '0;
      qt_q  <= '0;
      d_q   <= '0;
`ifdef IOBANK_IN_SYNC_EN
      d1_q  <= '0;
`endif
    end else begin
      sr_q  <= sr_d;
      act_q <= act_d;
      qo_q  <= qo_d;
      qt_q  <= qt_d;
      d_q   <= d_d;
`ifdef IOBANK_IN_SYNC_EN
      d1_q  <= d1_d;
`endif
    end
  end

  assign CFG_DOUT = sr_q[0];

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic [1:0] tsmux;
    logic       dorreg;
    logic       doreg;
    logic       cell_o;
    logic       cell_t;
    logic       cell_oe;

    assign tsmux  = act_q[4*i+1 -: 2];
    assign dorreg = act_q[4*i+2];
    assign doreg  = act_q[4*i+3];
    assign cell_o = doreg ? qo_q[i] : OUT[i];
    assign cell_t = doreg ? qt_q[i] : TS[i];

    always_comb begin
      cell_oe = 1'b0;
      case (tsmux)
        2'b00:   cell_oe = 1'b0;
        2'b01:   cell_oe = cell_t;
        2'b10:   cell_oe = 1'b1;
        default: cell_oe = ~cell_o;  // open-drain: only ever pulls low
      endcase
    end

    assign PIN[i] = cell_oe ? cell_o : 1'bz;
    assign IN[i]  = dorreg ? d_q[i] : PIN[i];
  end

endmodule
`default_nettype wire

// File: tb/tb_ioblock_bank.sv
`default_nettype none
// ==========================================================================
// tb_ioblock_bank : randomised self-checking bench for ioblock_bank (WIDTH=4).
// Rev 1.0
// ==========================================================================
module tb_ioblock_bank;
  localparam int W = 4;
  localparam int N = 4 * W;
  localparam int ZC = 2;  // observation code for a floating pin

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] ts = '0;
  logic [W-1:0] outv = '0;
  logic [W-1:0] ext_en = '0;
  logic [W-1:0] ext_val = '0;
  logic         shift = 1'b0;
  logic         din = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] in_w;
  logic         dout;
  wire  [W-1:0] pin;
  logic [W-1:0] pin_z;
  logic [W-1:0] pin_v;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ioblock_bank #(.WIDTH(W)) dut (
    .IOCLK(clk), .RESET(rst), .PIN(pin), .TS(ts), .OUT(outv), .IN(in_w),
    .CFG_SHIFT(shift), .CFG_DIN(din), .CFG_LOAD(load), .CFG_DOUT(dout)
  );

  for (genvar g = 0; g < W; g++) begin : g_pad
    assign pin[g]   = ext_en[g] ? ext_val[g] : 1'bz;
    assign pin_z[g] = (pin[g] === 1'bz);
    assign pin_v[g] = pin[g];
  end

  // Reference model: config chain as a bit queue (front = MSB), per-cell state as arrays.
  bit         chain[$];
  bit [N-1:0] act_m;
  bit         qo_m[W], qt_m[W], d_m[W], dk_m[W], d1_m[W], d1k_m[W];
  bit         res_val[W], res_known[W];

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int obs_pin(input int i);
    return pin_z[i] ? ZC : int'(pin_v[i]);
  endfunction

  task automatic model_reset();
    chain = {};
    for (int k = 0; k < N; k++) chain.push_back(1'b0);
    act_m = '0;
    for (int i = 0; i < W; i++) begin
      qo_m[i] = 0; qt_m[i] = 0; d_m[i] = 0; dk_m[i] = 1; d1_m[i] = 0; d1k_m[i] = 1;
    end
  endtask

  function automatic int exp_pin(input int i);
    int mux;
    bit o, t;
    mux = 2 * int'(act_m[4*i+1]) + int'(act_m[4*i]);
    o = act_m[4*i+3] ? qo_m[i] : outv[i];
    t = act_m[4*i+3] ? qt_m[i] : ts[i];
    case (mux)
      0:       return ZC;
      1:       return t ? int'(o) : ZC;
      2:       return int'(o);
      default: return o ? ZC : 0;
    endcase
  endfunction

  // xf < 0: random external drive on floating pins; xf = 0/1: force that value on them.
  task automatic step(input bit sh, input bit dn, input bit ld, input bit r,
                      input logic [W-1:0] t, input logic [W-1:0] o, input int xf);
    int e[W];
    @(negedge clk);
    shift = sh; din = dn; load = ld; ts = t; outv = o; rst = r;
    if (r) model_reset();
    for (int i = 0; i < W; i++) begin
      e[i] = exp_pin(i);
      if (e[i] == ZC) begin
        ext_en[i]  = (xf >= 0) ? 1'b1 : 1'($urandom_range(0, 1));
        ext_val[i] = (xf >= 0) ? 1'(xf) : 1'($urandom_range(0, 1));
        res_known[i] = ext_en[i];
        res_val[i]   = ext_val[i];
        if (ext_en[i]) e[i] = int'(ext_val[i]);
      end else begin
        ext_en[i]    = 1'b0;
        ext_val[i]   = 1'($urandom_range(0, 1));
        res_known[i] = 1;
        res_val[i]   = e[i][0];
      end
    end
    #1;
    for (int i = 0; i < W; i++) begin
      check_eq($sformatf("pin%0d", i), obs_pin(i), e[i]);
      if (act_m[4*i+2]) begin
        if (dk_m[i]) check_eq($sformatf("in_reg%0d", i), int'(in_w[i]), int'(d_m[i]));
      end else if (res_known[i]) begin
        check_eq($sformatf("in_comb%0d", i), int'(in_w[i]), int'(res_val[i]));
      end
    end
    check_eq("cfg_dout", int'(dout), int'(chain[N-1]));
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < W; i++) begin
        qo_m[i] = o[i];
        qt_m[i] = t[i];
`ifdef IOBANK_IN_SYNC_EN
        d_m[i] = d1_m[i]; dk_m[i] = d1k_m[i];
        d1_m[i] = res_val[i]; d1k_m[i] = res_known[i];
`else
        d_m[i] = res_val[i]; dk_m[i] = res_known[i];
`endif
      end
      if (ld) for (int k = 0; k < N; k++) act_m[k] = chain[N-1-k];
      if (sh) begin
        chain.push_front(dn);
        void'(chain.pop_back());
      end
    end
  endtask

  task automatic shift_word(input logic [N-1:0] w, input bit ld_last);
    for (int k = 0; k < N; k++)
      step(1'b1, w[k], 1'b0, 1'b0, 4'($urandom), 4'($urandom), -1);
    if (ld_last) step(1'b0, 1'b0, 1'b1, 1'b0, 4'($urandom), 4'($urandom), -1);
  endtask

  initial begin
    logic [N-1:0] pat_a;
    logic [N-1:0] pat_b;

    // Reset, then chain load of 16'h8421 (pins must stay Z until the load).
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, -1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 4'hF, 1);
    shift_word(16'h8421, 1'b1);

    // cell1 in mode 10 drives OUT[1] combinationally.
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0010, -1);
    #1 check_eq("c1_mode10", obs_pin(1), 1);

    // cell2 (TSMUX 00, DORREG): external 1 reaches IN after the input register latency.
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1);
    #1;
`ifdef IOBANK_IN_SYNC_EN
    check_eq("dorreg_lat1", int'(in_w[2]), 0);
`else
    check_eq("dorreg_lat1", int'(in_w[2]), 1);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1);
    #1 check_eq("dorreg_lat2", int'(in_w[2]), 1);

    // Config A631: c0 TS-enabled, c1 open-drain, c2 drive+DORREG, c3 drive+DOREG.
    shift_word(16'hA631, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001, -1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0001, -1);
    #1 check_eq("c0_ts_drive", obs_pin(0), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, -1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0010, -1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, -1);
    #1 check_eq("c3_doreg_old", obs_pin(3), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1000, -1);
    #1 check_eq("c3_doreg_new", obs_pin(3), 1);

    // Passthrough: 32 bits A then B; DOUT replays A starting after 16 shifts.
    pat_a = 16'hC35A;
    pat_b = 16'h0F96;
    for (int k = 0; k < 2 * N; k++) begin
      step(1'b1, (k < N) ? pat_a[k] : pat_b[k-N], 1'b0, 1'b0, 4'($urandom), 4'($urandom), -1);
      if (k >= N - 1 && k < 2 * N - 1) #1 check_eq("pass_a", int'(dout), int'(pat_a[k-N+1]));
    end
    // Simultaneous shift+load commits B (pre-shift contents).
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'($urandom), 4'($urandom), -1);
    for (int k = 0; k < 6; k++)
      step(1'b0, 1'b0, 1'b0, 1'b0, 4'($urandom), 4'($urandom), -1);

    // Reset after 8 of 16 bits, then load: everything floats.
    shift_word(16'hAAAA, 1'b1);
    for (int k = 0; k < 8; k++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 4'h0, -1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 4'h0, -1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 4'h0, -1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'h5, -1);

    // Randomised traffic.
    for (int c = 0; c < 600; c++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 59) == 0),
           4'($urandom), 4'($urandom), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
